// File: rtl/aes_gcm_pkg.sv
// Shared types and constants for the GCM stream decrypt slice.
// Counter constants, state encoding and the 128-bit block type.
package aes_gcm_pkg;

   typedef logic [127:0] block_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_STREAM,
      ST_TAG,
      ST_DONE
   } state_t;

   localparam logic [31:0] CTR_INIT = 32'd2;
   localparam logic [31:0] TAG_CTR  = 32'd1;

endpackage

// File: rtl/aes_gcm_stream_decrypt_if.sv
// Ciphertext-in / plaintext-out valid/ready stream bundle.
// slave is the decryptor's view, master is the producer/consumer side.
interface aes_gcm_stream_decrypt_if #(
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0] ct_data;
   logic              ct_valid;
   logic              ct_ready;
   logic [DATA_W-1:0] pt_data;
   logic              pt_valid;
   logic              pt_last;
   logic              pt_ready;

   modport slave (
      input  ct_data, ct_valid, pt_ready,
      output ct_ready, pt_data, pt_valid, pt_last
   );

   modport master (
      output ct_data, ct_valid, pt_ready,
      input  ct_ready, pt_data, pt_valid, pt_last
   );
endinterface

// File: rtl/gcm_tag_accum.sv
// Running tag accumulator: rotate-left-by-one then xor in each
// ciphertext word, zero-extended to a full block.
module gcm_tag_accum
   import aes_gcm_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clear,
   input  logic              update,
   input  logic [DATA_W-1:0] data,
   output block_t            acc
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc <= '0;
      end else if (clear) begin
         acc <= '0;
      end else if (update) begin
         acc <= {acc[126:0], acc[127]} ^ block_t'(data);
      end
   end

endmodule

// File: rtl/aes_gcm_stream_decrypt.sv
// Streaming GCM-style decryptor: counter keystream xor, tag accumulate,
// tag compare, idle-timeout abort.
module aes_gcm_stream_decrypt
   import aes_gcm_pkg::*;
#(
   parameter int DATA_W       = 32,
   parameter int LEN_W        = 16,
   parameter int IDLE_TIMEOUT = 100
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [255:0]     key,
   input  logic [95:0]      iv,
   input  logic             start,
   input  logic [LEN_W-1:0] msg_len,
   input  block_t           tag_in,
   output logic             busy,
   output logic             auth_done,
   output logic             auth_ok,
   output logic             error,
   aes_gcm_stream_decrypt_if.slave strm
);

   state_t           state, state_nx;
   logic [255:0]     key_q;
   logic [95:0]      iv_q;
   logic [LEN_W-1:0] len_q;
   block_t           tag_q;
   logic [31:0]      idx;
   logic [31:0]      idle_cnt;
   logic             ok_q, err_q;
   logic             start_ok, xfer, last_w, timeout;
   block_t           j_blk, ks_blk, acc, tag_calc;

   assign start_ok = start && (state == ST_IDLE);
   assign xfer     = strm.ct_valid && strm.ct_ready;
   assign last_w   = idx == (32'(len_q) - 32'd1);
   assign timeout  = (state == ST_STREAM) && !strm.ct_valid &&
                     (idle_cnt == 32'(IDLE_TIMEOUT - 1));

   // Counter field wraps on its own 32 bits, never touching iv.
   assign j_blk    = {iv_q, CTR_INIT + idx};
   assign ks_blk   = key_q[127:0] ^ j_blk;
   assign tag_calc = acc ^ key_q[255:128] ^ {iv_q, TAG_CTR};

   gcm_tag_accum #(
      .DATA_W (DATA_W)
   ) u_acc (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (start_ok),
      .update  (xfer),
      .data    (strm.ct_data),
      .acc     (acc)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE:
            if (start)
               state_nx = (msg_len == '0) ? ST_TAG : ST_STREAM;
         ST_STREAM:
            if (xfer && last_w) state_nx = ST_TAG;
            else if (timeout)   state_nx = ST_DONE;
         ST_TAG:  state_nx = ST_DONE;
         ST_DONE: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      busy          = state != ST_IDLE;
      auth_done     = state == ST_DONE;
      auth_ok       = auth_done && ok_q;
      error         = auth_done && err_q;
      strm.ct_ready = (state == ST_STREAM) &&
                      (!strm.pt_valid || strm.pt_ready);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         key_q         <= '0;
         iv_q          <= '0;
         len_q         <= '0;
         tag_q         <= '0;
         idx           <= '0;
         idle_cnt      <= '0;
         ok_q          <= 1'b0;
         err_q         <= 1'b0;
         strm.pt_data  <= '0;
         strm.pt_valid <= 1'b0;
         strm.pt_last  <= 1'b0;
      end else begin
         if (start_ok) begin
            key_q    <= key;
            iv_q     <= iv;
            len_q    <= msg_len;
            idx      <= '0;
            idle_cnt <= '0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
         end
         if (state == ST_STREAM)
            idle_cnt <= strm.ct_valid ? '0 : idle_cnt + 32'd1;
         if (xfer) begin
            idx          <= idx + 32'd1;
            strm.pt_data <= strm.ct_data ^ ks_blk[DATA_W-1:0];
            strm.pt_last <= last_w;
         end
         if (xfer)               strm.pt_valid <= 1'b1;
         else if (strm.pt_ready) strm.pt_valid <= 1'b0;
         if (timeout) begin
            ok_q  <= 1'b0;
            err_q <= 1'b1;
         end
         if ((state_nx == ST_TAG) && (state != ST_TAG))
            tag_q <= tag_in;
         if (state == ST_TAG)
            ok_q <= tag_calc == tag_q;
      end
   end

endmodule
